// File: rtl/bus_lane_serializer_pkg.sv
// rtl/bus_lane_serializer_pkg.sv - shared Ctrl codes, state enum and beat-count helper
package bus_lane_serializer_pkg;

    localparam logic [1:0] CTRL_B4_LSB = 2'b00;
    localparam logic [1:0] CTRL_B4_MSB = 2'b01;
    localparam logic [1:0] CTRL_B2     = 2'b10;
    localparam logic [1:0] CTRL_B1     = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Number of beats emitted for one accepted word under a given Ctrl code.
    function automatic logic [2:0] beat_count(input logic [1:0] ctrl);
        logic [2:0] n;
        case (ctrl)
            CTRL_B4_LSB: n = 3'd4;
            CTRL_B4_MSB: n = 3'd4;
            CTRL_B2:     n = 3'd2;
            default:     n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bus_lane_serializer_lane_select.sv
// rtl/bus_lane_serializer_lane_select.sv - combinational byte-lane mux for the current beat
module bus_lane_serializer_lane_select
    import bus_lane_serializer_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [4*LANE_W-1:0] word,
    input  logic [1:0]          ctrl,
    input  logic [1:0]          index,
    output logic [LANE_W-1:0]   lane_out
);

    logic [1:0] lane;

    // Map (ctrl, beat index) to the physical lane number.
    always_comb begin
        lane = 2'd0;
        case (ctrl)
            CTRL_B4_LSB: lane = index;
            CTRL_B4_MSB: lane = 2'd3 - index;
            CTRL_B2:     lane = {1'b0, index[0]};
            default:     lane = 2'd0;
        endcase
    end

    // Pick the selected lane out of the latched word.
    always_comb begin
        lane_out = word[LANE_W-1:0];
        case (lane)
            2'd0:    lane_out = word[LANE_W-1:0];
            2'd1:    lane_out = word[2*LANE_W-1:LANE_W];
            2'd2:    lane_out = word[3*LANE_W-1:2*LANE_W];
            default: lane_out = word[4*LANE_W-1:3*LANE_W];
        endcase
    end

endmodule

// File: rtl/bus_lane_serializer.sv
// rtl/bus_lane_serializer.sv - serializes a store-bus word into byte-lane beats
module bus_lane_serializer
    import bus_lane_serializer_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*LANE_W-1:0] DB,
    input  logic [1:0]          Ctrl,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LANE_W-1:0]   Lane_Out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy
);

    state_e              state_q, state_d;
    logic [4*LANE_W-1:0] word_q, word_d;
    logic [1:0]          ctrl_q, ctrl_d;
    logic [1:0]          index_q, index_d;

    logic xfer;
    logic accept;

    // Handshake flags derived purely from registered state plus the sink/source strobes.
    always_comb begin
        out_valid = (state_q == SEND);
        busy      = (state_q == SEND);
        out_last  = out_valid && ({1'b0, index_q} == (beat_count(ctrl_q) - 3'd1));
        xfer      = out_valid && out_ready;
        in_ready  = (state_q == IDLE) || (xfer && out_last);
        accept    = in_valid && in_ready;
    end

    // Next-state: a new word wins over the end of the current one, giving gapless back-to-back.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ctrl_d  = ctrl_q;
        index_d = index_q;
        if (accept) begin
            word_d  = DB;
            ctrl_d  = Ctrl;
            index_d = 2'd0;
            state_d = SEND;
        end else if (xfer) begin
            if (out_last) begin
                state_d = IDLE;
                index_d = 2'd0;
            end else begin
                index_d = index_q + 2'd1;
            end
        end
    end

    // State registers with synchronous reset discarding any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            ctrl_q  <= CTRL_B4_LSB;
            index_q <= 2'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            ctrl_q  <= ctrl_d;
            index_q <= index_d;
        end
    end

    bus_lane_serializer_lane_select #(
        .LANE_W (LANE_W)
    ) u_lane_select (
        .word     (word_q),
        .ctrl     (ctrl_q),
        .index    (index_q),
        .lane_out (Lane_Out)
    );

endmodule

// File: tb/tb_bus_lane_serializer.sv
// tb/tb_bus_lane_serializer.sv - self-checking bench for bus_lane_serializer
module tb_bus_lane_serializer;

    logic        clk;
    logic        rst;
    logic [31:0] DB;
    logic [1:0]  Ctrl;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  Lane_Out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int checks;
    int errors;

    bus_lane_serializer #(.LANE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .DB        (DB),
        .Ctrl      (Ctrl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Lane_Out  (Lane_Out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the byte sequence a word should produce under a Ctrl code.
    function automatic void model_beats(input logic [31:0] w, input logic [1:0] c,
                                        output logic [7:0] b [4], output int n);
        int lanes [4];
        case (c)
            2'b00: begin lanes = '{0, 1, 2, 3}; n = 4; end
            2'b01: begin lanes = '{3, 2, 1, 0}; n = 4; end
            2'b10: begin lanes = '{0, 1, 0, 0}; n = 2; end
            default: begin lanes = '{0, 0, 0, 0}; n = 1; end
        endcase
        for (int i = 0; i < 4; i++) b[i] = 8'((w >> (8 * lanes[i])) & 32'hFF);
    endfunction

    // Send one word from IDLE and follow every beat; junk DB/Ctrl is offered while stalled.
    task automatic run_word(input logic [31:0] w, input logic [1:0] c,
                            input logic [31:0] pat, input bit rnd, input bit chk_tput);
        logic [7:0] exp_b [4];
        int n, k, cyc;
        logic rdy;
        model_beats(w, c, exp_b, n);
        DB = w; Ctrl = c; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        k = 0; cyc = 0;
        while (k < n && cyc < 64) begin
            rdy = rnd ? ($urandom_range(0, 3) != 0) : pat[cyc % 32];
            out_ready = rdy;
            DB = $urandom; Ctrl = 2'($urandom); in_valid = !rdy;
            #1;
            chk("beat_valid", out_valid, 1);
            chk("beat_busy", busy, 1);
            chk("beat_data", Lane_Out, exp_b[k]);
            chk("beat_last", out_last, (k == n - 1) ? 1 : 0);
            chk("beat_in_ready", in_ready, (rdy && k == n - 1) ? 1 : 0);
            if (rdy) k++;
            cyc++;
            step();
        end
        if (k < n) begin
            errors++;
            $display("FAIL word_timeout: observed %0d beats required %0d", k, n);
        end
        in_valid = 1'b0;
        #1;
        chk("post_out_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_in_ready", in_ready, 1);
        if (chk_tput) chk("throughput_cycles", cyc, n);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; DB = '0; Ctrl = 2'b00; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lane_out", Lane_Out, 0);
        chk("rst_in_ready", in_ready, 1);

        // Every Ctrl code with the sink always ready.
        for (int c = 0; c < 4; c++) run_word(32'hAABBCCDD, 2'(c), 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Stall pattern 1,0,0,1,1,0,1.
        run_word(32'hAABBCCDD, 2'b00, 32'h0000_0059, 1'b0, 1'b0);

        // Back-to-back: 11223344/Ctrl=10 then 55667788/Ctrl=11 with in_valid held.
        DB = 32'h11223344; Ctrl = 2'b10; in_valid = 1'b1; out_ready = 1'b1;
        step();
        DB = 32'h55667788; Ctrl = 2'b11;
        #1;
        chk("b2b_beat0", Lane_Out, 8'h44);
        chk("b2b_beat0_last", out_last, 0);
        chk("b2b_beat0_in_ready", in_ready, 0);
        step();
        #1;
        chk("b2b_beat1", Lane_Out, 8'h33);
        chk("b2b_beat1_last", out_last, 1);
        chk("b2b_beat1_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        #1;
        chk("b2b_beat2_valid", out_valid, 1);
        chk("b2b_beat2", Lane_Out, 8'h88);
        chk("b2b_beat2_last", out_last, 1);
        chk("b2b_beat2_in_ready", in_ready, 1);
        step();
        chk("b2b_idle", out_valid, 0);

        // Reset mid-transfer after two beats of 01020304.
        DB = 32'h01020304; Ctrl = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        chk("rstmid_beat0", Lane_Out, 8'h04);
        step();
        #1;
        chk("rstmid_beat1", Lane_Out, 8'h03);
        step();
        out_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_lane_out", Lane_Out, 0);
        chk("rstmid_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("rstmid_no_beats", out_valid, 0);
        run_word(32'hCAFEF00D, 2'b00, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Random words, codes and sink back-pressure.
        for (int i = 0; i < 40; i++) run_word($urandom, 2'($urandom), 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
